// File: rtl/btb_banked_pkg.sv
// ============================================================================
// Module   : btb_banked_pkg
// Purpose  : Shared types and geometry for the multi-bank BTB.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package btb_banked_pkg;

    localparam int unsigned VLEN            = 64;
    localparam int unsigned INSTR_PER_FETCH = 2;
    localparam int unsigned ROW_ADDR_BITS   = $clog2(INSTR_PER_FETCH);

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic [VLEN-1:0] target_address;
    } btb_update_t;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] target_address;
    } btb_prediction_t;

    typedef btb_prediction_t [INSTR_PER_FETCH-1:0] btb_row_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COPY = 2'd1,
        DONE = 2'd2
    } btb_copy_state_e;

endpackage

`default_nettype wire

// File: rtl/btb_banked_bank.sv
// ============================================================================
// Module   : btb_banked_bank
// Purpose  : Storage for one BTB context: prediction read port, copy read
//            port, slot update port, whole-row copy write port and flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btb_banked_bank
    import btb_banked_pkg::*;
#(
    parameter int unsigned NR_ROWS = 4,
    parameter int unsigned ROW_W   = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic [ROW_W-1:0]         rd_row_i,
    output btb_row_t                 rd_data_o,
    input  logic [ROW_W-1:0]         cp_row_i,
    output btb_row_t                 cp_data_o,
    input  logic                     upd_we_i,
    input  logic [ROW_W-1:0]         upd_row_i,
    input  logic [ROW_ADDR_BITS-1:0] upd_slot_i,
    input  logic [VLEN-1:0]          upd_target_i,
    input  logic                     row_we_i,
    input  logic [ROW_W-1:0]         row_idx_i,
    input  btb_row_t                 row_data_i
);

    btb_row_t [NR_ROWS-1:0] mem_d;
    btb_row_t [NR_ROWS-1:0] mem_q;

    assign rd_data_o = mem_q[rd_row_i];
    assign cp_data_o = mem_q[cp_row_i];

    // Later assignments win: slot update overrides a copy row, flush overrides both.
    always_comb begin
        mem_d = mem_q;
        if (row_we_i) begin
            mem_d[row_idx_i] = row_data_i;
        end
        if (upd_we_i) begin
            mem_d[upd_row_i][upd_slot_i].valid          = 1'b1;
            mem_d[upd_row_i][upd_slot_i].target_address = upd_target_i;
        end
        if (flush_i) begin
            for (int unsigned r = 0; r < NR_ROWS; r++) begin
                for (int unsigned s = 0; s < INSTR_PER_FETCH; s++) begin
                    mem_d[r][s].valid = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/btb_banked.sv
// ============================================================================
// Module   : btb_banked
// Purpose  : Multi-bank branch target buffer with handshaked bank switch,
//            scoped flush and a row-sequential bank-to-bank copy engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btb_banked
    import btb_banked_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = 8,
    parameter int unsigned NR_BANKS   = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  flush_i,
    input  logic                                  flush_all_i,
    input  logic                                  debug_mode_i,
    input  logic [VLEN-1:0]                       vpc_i,
    input  btb_update_t                           btb_update_i,
    output btb_prediction_t [INSTR_PER_FETCH-1:0] btb_prediction_o,
    input  logic                                  sel_valid_i,
    input  logic [$clog2(NR_BANKS)-1:0]           sel_bank_i,
    output logic                                  sel_ready_o,
    output logic [$clog2(NR_BANKS)-1:0]           active_bank_o,
    input  logic                                  copy_req_i,
    input  logic [$clog2(NR_BANKS)-1:0]           copy_src_i,
    input  logic [$clog2(NR_BANKS)-1:0]           copy_dst_i,
    output logic                                  copy_busy_o,
    output logic                                  copy_done_o
);

    localparam int unsigned BANK_W  = $clog2(NR_BANKS);
    localparam int unsigned NR_ROWS = NR_ENTRIES / INSTR_PER_FETCH;
    localparam int unsigned ROW_W   = (NR_ROWS > 1) ? $clog2(NR_ROWS) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NR_ROWS - 1);

    // NR_ROWS is a power of two, so the last row index doubles as the row mask.
    function automatic logic [ROW_W-1:0] row_of(input logic [VLEN-1:0] pc);
        row_of = ROW_W'(pc >> (ROW_ADDR_BITS + 1)) & ROW_LAST;
    endfunction

    logic [BANK_W-1:0]        active_bank_d, active_bank_q;
    logic                     upd_valid_d, upd_valid_q;
    logic [BANK_W-1:0]        upd_bank_d, upd_bank_q;
    logic [ROW_W-1:0]         upd_row_d, upd_row_q;
    logic [ROW_ADDR_BITS-1:0] upd_slot_d, upd_slot_q;
    logic [VLEN-1:0]          upd_target_d, upd_target_q;
    btb_copy_state_e          state_d, state_q;
    logic [BANK_W-1:0]        src_d, src_q;
    logic [BANK_W-1:0]        dst_d, dst_q;
    logic [ROW_W-1:0]         row_d, row_q;
    logic [NR_ROWS-1:0]       dirty_d, dirty_q;

    logic     flush_any;
    logic     upd_we;
    logic     upd_hits_dst_row;
    logic     copy_we;
    logic     busy;
    logic     done;
    btb_row_t rd_data [NR_BANKS];
    btb_row_t cp_data [NR_BANKS];
    btb_row_t copy_row;
    logic     unused_pc_bits;

    assign unused_pc_bits = ^{vpc_i, btb_update_i.pc};

    assign flush_any = flush_i | flush_all_i;
    assign upd_we    = upd_valid_q & ~flush_any;

    // An update landing on the row being copied owns that row from now on.
    assign upd_hits_dst_row = upd_we && (state_q == COPY) &&
                              (upd_bank_q == dst_q) && (upd_row_q == row_q);
    assign copy_we  = (state_q == COPY) && !flush_any &&
                      !dirty_q[row_q] && !upd_hits_dst_row;
    assign copy_row = cp_data[src_q];

    for (genvar g = 0; g < NR_BANKS; g++) begin : g_bank
        logic bank_flush;
        logic bank_upd_we;
        logic bank_row_we;

        assign bank_flush  = flush_all_i | (flush_i & (active_bank_q == BANK_W'(g)));
        assign bank_upd_we = upd_we & (upd_bank_q == BANK_W'(g));
        assign bank_row_we = copy_we & (dst_q == BANK_W'(g));

        btb_banked_bank #(
            .NR_ROWS (NR_ROWS),
            .ROW_W   (ROW_W)
        ) i_bank (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .flush_i      (bank_flush),
            .rd_row_i     (row_of(vpc_i)),
            .rd_data_o    (rd_data[g]),
            .cp_row_i     (row_q),
            .cp_data_o    (cp_data[g]),
            .upd_we_i     (bank_upd_we),
            .upd_row_i    (upd_row_q),
            .upd_slot_i   (upd_slot_q),
            .upd_target_i (upd_target_q),
            .row_we_i     (bank_row_we),
            .row_idx_i    (row_q),
            .row_data_i   (copy_row)
        );
    end

    assign btb_prediction_o = rd_data[active_bank_q];
    assign active_bank_o    = active_bank_q;
    assign sel_ready_o      = ~busy;
    assign copy_busy_o      = busy;
    assign copy_done_o      = done;

    // Updates are tagged with the bank that was active when they were sampled.
    always_comb begin
        upd_valid_d   = btb_update_i.valid & ~debug_mode_i;
        upd_bank_d    = active_bank_q;
        upd_row_d     = row_of(btb_update_i.pc);
        upd_slot_d    = btb_update_i.pc[1 +: ROW_ADDR_BITS];
        upd_target_d  = btb_update_i.target_address;
        active_bank_d = (sel_valid_i && !busy) ? sel_bank_i : active_bank_q;
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        row_d   = row_q;
        dirty_d = dirty_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (copy_req_i && (copy_src_i != copy_dst_i)) begin
                    state_d = COPY;
                    src_d   = copy_src_i;
                    dst_d   = copy_dst_i;
                    row_d   = '0;
                    dirty_d = '0;
                end
            end
            COPY: begin
                busy = 1'b1;
                if (upd_we && (upd_bank_q == dst_q)) begin
                    dirty_d[upd_row_q] = 1'b1;
                end
                if (flush_any) begin
                    state_d = IDLE;
                end else if (row_q == ROW_LAST) begin
                    state_d = DONE;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = ~flush_any;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_bank_q <= '0;
            upd_valid_q   <= 1'b0;
            upd_bank_q    <= '0;
            upd_row_q     <= '0;
            upd_slot_q    <= '0;
            upd_target_q  <= '0;
            state_q       <= IDLE;
            src_q         <= '0;
            dst_q         <= '0;
            row_q         <= '0;
            dirty_q       <= '0;
        end else begin
            active_bank_q <= active_bank_d;
            upd_valid_q   <= upd_valid_d;
            upd_bank_q    <= upd_bank_d;
            upd_row_q     <= upd_row_d;
            upd_slot_q    <= upd_slot_d;
            upd_target_q  <= upd_target_d;
            state_q       <= state_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            row_q         <= row_d;
            dirty_q       <= dirty_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_btb_banked.sv
// ============================================================================
// Module   : tb_btb_banked
// Purpose  : Self-checking bench for btb_banked (4 banks, 8 entries).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btb_banked;
    import btb_banked_pkg::*;

    localparam int NB  = 4;
    localparam int NE  = 8;
    localparam int IPF = INSTR_PER_FETCH;
    localparam int R   = NE / IPF;

    logic                              clk = 1'b0;
    logic                              rst_ni = 1'b0;
    logic                              flush = 1'b0;
    logic                              flush_all = 1'b0;
    logic                              debug = 1'b0;
    logic [VLEN-1:0]                   vpc = '0;
    btb_update_t                       upd = '0;
    btb_prediction_t [IPF-1:0]         pred;
    logic                              sel_valid = 1'b0;
    logic [1:0]                        sel_bank = '0;
    logic                              sel_ready;
    logic [1:0]                        active_bank;
    logic                              copy_req = 1'b0;
    logic [1:0]                        copy_src = '0;
    logic [1:0]                        copy_dst = '0;
    logic                              copy_busy;
    logic                              copy_done;

    int checks = 0;
    int failures = 0;

    // Reference model: flat entry arrays per bank, copy progress as a phase
    // counter (-1 idle, 0..R-1 copying that row, R = done pulse).
    bit          mv [NB][NE];
    logic [63:0] mt [NB][NE];
    bit          m_dirty [R];
    int          phase, m_src, m_dst, m_active;
    bit          pu_valid;
    int          pu_bank, pu_idx;
    logic [63:0] pu_tgt;

    btb_banked #(
        .NR_ENTRIES (NE),
        .NR_BANKS   (NB)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .flush_i          (flush),
        .flush_all_i      (flush_all),
        .debug_mode_i     (debug),
        .vpc_i            (vpc),
        .btb_update_i     (upd),
        .btb_prediction_o (pred),
        .sel_valid_i      (sel_valid),
        .sel_bank_i       (sel_bank),
        .sel_ready_o      (sel_ready),
        .active_bank_o    (active_bank),
        .copy_req_i       (copy_req),
        .copy_src_i       (copy_src),
        .copy_dst_i       (copy_dst),
        .copy_busy_o      (copy_busy),
        .copy_done_o      (copy_done)
    );

    always #5 clk = ~clk;

    function automatic int pc_row(input logic [63:0] pc);
        return int'((pc >> 2) % R);
    endfunction

    function automatic int pc_idx(input logic [63:0] pc);
        return pc_row(pc) * IPF + int'((pc >> 1) & 64'd1);
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int b = 0; b < NB; b++)
            for (int e = 0; e < NE; e++) begin
                mv[b][e] = 1'b0;
                mt[b][e] = '0;
            end
        for (int r = 0; r < R; r++) m_dirty[r] = 1'b0;
        phase = -1; m_src = 0; m_dst = 0; m_active = 0;
        pu_valid = 1'b0; pu_bank = 0; pu_idx = 0; pu_tgt = '0;
    endtask

    task automatic check_outputs();
        bit fl;
        int base;
        fl = flush || flush_all;
        cmp("sel_ready", 64'(sel_ready), 64'(phase < 0));
        cmp("copy_busy", 64'(copy_busy), 64'(phase >= 0));
        cmp("copy_done", 64'(copy_done), 64'(phase == R && !fl));
        cmp("active_bank", 64'(active_bank), 64'(m_active));
        base = pc_row(vpc) * IPF;
        for (int s = 0; s < IPF; s++) begin
            cmp("pred_valid", 64'(pred[s].valid), 64'(mv[m_active][base + s]));
            if (mv[m_active][base + s])
                cmp("pred_target", pred[s].target_address, mt[m_active][base + s]);
        end
    endtask

    task automatic model_step();
        bit fl, was_busy;
        int k;
        fl = flush || flush_all;
        was_busy = (phase >= 0);
        if (phase >= 0 && phase < R && !fl) begin
            k = phase;
            if (!m_dirty[k] && !(pu_valid && pu_bank == m_dst && pu_idx / IPF == k))
                for (int s = 0; s < IPF; s++) begin
                    mv[m_dst][k*IPF + s] = mv[m_src][k*IPF + s];
                    mt[m_dst][k*IPF + s] = mt[m_src][k*IPF + s];
                end
        end
        if (pu_valid && !fl) begin
            mv[pu_bank][pu_idx] = 1'b1;
            mt[pu_bank][pu_idx] = pu_tgt;
            if (phase >= 0 && phase < R && pu_bank == m_dst) m_dirty[pu_idx / IPF] = 1'b1;
        end
        if (flush_all) begin
            for (int b = 0; b < NB; b++)
                for (int e = 0; e < NE; e++) mv[b][e] = 1'b0;
        end else if (flush) begin
            for (int e = 0; e < NE; e++) mv[m_active][e] = 1'b0;
        end
        if (phase < 0) begin
            if (copy_req && copy_src != copy_dst) begin
                phase = 0; m_src = int'(copy_src); m_dst = int'(copy_dst);
                for (int r = 0; r < R; r++) m_dirty[r] = 1'b0;
            end
        end else if (phase < R) begin
            phase = fl ? -1 : phase + 1;
        end else begin
            phase = -1;
        end
        pu_valid = upd.valid && !debug;
        pu_bank  = m_active;
        pu_idx   = pc_idx(upd.pc);
        pu_tgt   = upd.target_address;
        if (sel_valid && !was_busy) m_active = int'(sel_bank);
    endtask

    // Every clock cycle goes through here: compare, advance model, edge.
    task automatic tick();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; flush_all = 0; debug = 0; upd = '0;
        sel_valid = 0; copy_req = 0;
    endtask

    task automatic do_update(input logic [63:0] pc, input logic [63:0] tgt);
        upd.valid = 1'b1; upd.pc = pc; upd.target_address = tgt;
        tick();
        upd = '0;
    endtask

    task automatic do_switch(input logic [1:0] b);
        sel_valid = 1'b1; sel_bank = b;
        tick();
        sel_valid = 1'b0;
    endtask

    initial begin
        m_reset();
        @(posedge clk); @(posedge clk); #1;
        vpc = 64'h8000_0010;
        #1;
        cmp("reset_pred0_valid", 64'(pred[0].valid), 64'd0);
        cmp("reset_pred1_valid", 64'(pred[1].valid), 64'd0);
        cmp("reset_active", 64'(active_bank), 64'd0);
        cmp("reset_ready", 64'(sel_ready), 64'd1);
        cmp("reset_busy", 64'(copy_busy), 64'd0);
        cmp("reset_done", 64'(copy_done), 64'd0);
        rst_ni = 1'b1;

        // Update on bank 0 is invisible from bank 2.
        do_update(64'h8000_0010, 64'h8000_0100);
        tick();
        do_switch(2'd2);
        vpc = 64'h8000_0010; #1;
        cmp("bank2_active", 64'(active_bank), 64'd2);
        cmp("bank2_invalid", 64'(pred[0].valid), 64'd0);
        do_switch(2'd0);
        #1;
        cmp("bank0_valid", 64'(pred[0].valid), 64'd1);
        cmp("bank0_target", pred[0].target_address, 64'h8000_0100);

        // Update sampled in the switch cycle belongs to the old bank.
        upd.valid = 1'b1; upd.pc = 64'h8000_0014; upd.target_address = 64'h8000_0200;
        do_switch(2'd1);
        upd = '0;
        tick();
        vpc = 64'h8000_0014; #1;
        cmp("sw_active1", 64'(active_bank), 64'd1);
        cmp("sw_bank1_invalid", 64'(pred[0].valid), 64'd0);
        do_switch(2'd0);
        #1;
        cmp("sw_bank0_valid", 64'(pred[0].valid), 64'd1);
        cmp("sw_bank0_target", pred[0].target_address, 64'h8000_0200);

        // Copy 0 -> 3: busy five cycles, done on the fifth, switch blocked.
        copy_req = 1'b1; copy_src = 2'd0; copy_dst = 2'd3;
        tick();
        copy_req = 1'b0;
        for (int c = 1; c <= R + 1; c++) begin
            sel_valid = 1'b1; sel_bank = 2'd2;
            #1;
            cmp("copy_busy_lit", 64'(copy_busy), 64'd1);
            cmp("copy_ready_lit", 64'(sel_ready), 64'd0);
            cmp("copy_done_lit", 64'(copy_done), 64'(c == R + 1));
            tick();
        end
        sel_valid = 1'b0; #1;
        cmp("copy_busy_after", 64'(copy_busy), 64'd0);
        cmp("copy_active_kept", 64'(active_bank), 64'd0);
        do_switch(2'd3);
        vpc = 64'h8000_0010; #1;
        cmp("copy_row0_valid", 64'(pred[0].valid), 64'd1);
        cmp("copy_row0_target", pred[0].target_address, 64'h8000_0100);
        vpc = 64'h8000_0014; #1;
        cmp("copy_row1_target", pred[0].target_address, 64'h8000_0200);

        // Update to dst row 3 during copy wins over the source row.
        do_switch(2'd0);
        do_update(64'h8000_001C, 64'h8000_0300);
        tick();
        do_switch(2'd3);
        copy_req = 1'b1; copy_src = 2'd0; copy_dst = 2'd3;
        tick();
        copy_req = 1'b0;
        do_update(64'h8000_001C, 64'h8000_0444);
        repeat (R) tick();
        vpc = 64'h8000_001C; #1;
        cmp("dirty_row_valid", 64'(pred[0].valid), 64'd1);
        cmp("dirty_row_target", pred[0].target_address, 64'h8000_0444);

        // flush_all in copy cycle 2 aborts with no done pulse.
        copy_req = 1'b1; copy_src = 2'd0; copy_dst = 2'd1;
        tick();
        copy_req = 1'b0;
        tick();
        flush_all = 1'b1; #1;
        cmp("abort_busy_before", 64'(copy_busy), 64'd1);
        cmp("abort_done_masked", 64'(copy_done), 64'd0);
        tick();
        flush_all = 1'b0; #1;
        cmp("abort_busy_after", 64'(copy_busy), 64'd0);
        for (int b = 0; b < NB; b++) begin
            do_switch(2'(b));
            vpc = 64'h8000_0010; #1;
            cmp("abort_bank_invalid", 64'(pred[0].valid), 64'd0);
        end

        // Debug mode suppresses the update.
        debug = 1'b1;
        do_update(64'h8000_0010, 64'h8000_0999);
        debug = 1'b0;
        tick();
        vpc = 64'h8000_0010; #1;
        cmp("debug_no_write", 64'(pred[0].valid), 64'd0);

        // Randomized traffic against the model.
        repeat (3000) begin
            upd.valid          = 1'($urandom_range(0, 1));
            upd.pc             = 64'h8000_0000 | 64'($urandom_range(0, 31) << 1);
            upd.target_address = {$urandom, $urandom};
            debug              = ($urandom_range(0, 9) == 0);
            flush              = ($urandom_range(0, 39) == 0);
            flush_all          = ($urandom_range(0, 79) == 0);
            sel_valid          = ($urandom_range(0, 4) == 0);
            sel_bank           = 2'($urandom_range(0, 3));
            copy_req           = ($urandom_range(0, 7) == 0);
            copy_src           = 2'($urandom_range(0, 3));
            copy_dst           = 2'($urandom_range(0, 3));
            vpc                = 64'h8000_0000 | 64'($urandom_range(0, 31) << 1);
            tick();
        end

        // Asynchronous reset in the middle of a copy.
        idle_inputs();
        repeat (R + 3) tick();
        sel_valid = 1'b1; sel_bank = 2'd1;
        copy_req = 1'b1; copy_src = 2'd1; copy_dst = 2'd2;
        tick();
        idle_inputs();
        tick();
        cmp("arst_busy_before", 64'(copy_busy), 64'd1);
        cmp("arst_active_before", 64'(active_bank), 64'd1);
        rst_ni = 1'b0; #1;
        cmp("arst_busy", 64'(copy_busy), 64'd0);
        cmp("arst_ready", 64'(sel_ready), 64'd1);
        cmp("arst_active", 64'(active_bank), 64'd0);
        cmp("arst_pred", 64'(pred[0].valid | pred[1].valid), 64'd0);
        m_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk); #1;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
